// File: rtl/button_pkg.sv
// Shared types and constants for the push-button debouncer (clk50 board).
package button_pkg;

    typedef enum logic [1:0] {
        IDLE            = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        HELD            = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } btn_state_e;

    localparam int unsigned PRESS_CNT_W         = 6;
    localparam int unsigned DEF_NUM_BTN         = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms at 50 MHz
    localparam int unsigned DEF_LONG_CYCLES     = 50000000;  // 1 s at 50 MHz
    localparam int unsigned DEF_CNT_W           = 26;

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side bus: raw active-low pins in, debounced levels, strobes and press count out.
interface button_debouncer_if #(
    parameter int unsigned NUM_BTN = 4
) ();
    import button_pkg::*;

    logic [NUM_BTN-1:0]     btn_n_raw;
    logic [NUM_BTN-1:0]     btn_level;
    logic [NUM_BTN-1:0]     press_pulse;
    logic [NUM_BTN-1:0]     release_pulse;
    logic [NUM_BTN-1:0]     long_pulse;
    logic [PRESS_CNT_W-1:0] press_count;

    modport master (
        output btn_n_raw,
        input  btn_level, press_pulse, release_pulse, long_pulse, press_count
    );

    modport slave (
        input  btn_n_raw,
        output btn_level, press_pulse, release_pulse, long_pulse, press_count
    );
endinterface

// File: rtl/button_debouncer_debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional hold timer.
// Long-press detection is built only when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module debounce_chan
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk50,
    input  logic rst,
    input  logic btn_n_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES ||
        $clog2(LONG_CYCLES + 1) > CNT_W) begin : g_bad_cfg
        $error("debounce_chan: illegal DEBOUNCE_CYCLES / LONG_CYCLES / CNT_W");
    end

    logic       sync1_q, sync2_q;
    logic       sync_n;
    btn_state_e state_q, state_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

    // Flops reset to 1 so a pin held through reset still looks released.
    always_ff @(posedge clk50) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign sync_n = ~sync2_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             long_q, long_d;

    always_ff @(posedge clk50) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q   <= IDLE;
            deb_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Hold count freezes in CONFIRM_RELEASE so a release bounce cannot re-arm long_o.
    always_comb begin
        state_d   = state_q;
        deb_d     = deb_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        hold_d    = hold_q;
        long_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sync_n) begin
                    state_d = CONFIRM_PRESS;
                    deb_d   = DEB_W'(1);
                end
            end
            CONFIRM_PRESS: begin
                if (!sync_n) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = HELD;
                    deb_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
                    hold_d  = '0;
`endif
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            HELD: begin
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
                if (hold_q != CNT_W'(LONG_CYCLES)) begin
                    hold_d = hold_q + CNT_W'(1);
                    long_d = (hold_q == CNT_W'(LONG_CYCLES - 1));
                end
`endif
                if (!sync_n) begin
                    state_d = CONFIRM_RELEASE;
                    deb_d   = DEB_W'(1);
                end
            end
            CONFIRM_RELEASE: begin
                if (sync_n) begin
                    state_d = HELD;
                    deb_d   = '0;
                end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d   = IDLE;
                    deb_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
                    hold_d    = '0;
`endif
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// NUM_BTN debounced push-buttons plus a wrap-around 6-bit press counter for the board LEDs.
// Long-press strobes exist only when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic               clk50,
    input  logic               rst,
    button_debouncer_if.slave  bus
);

    logic [NUM_BTN-1:0]     level_w, press_w, release_w, long_w;
    logic [PRESS_CNT_W-1:0] press_inc_c;
    logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;

    for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk50       (clk50),
            .rst         (rst),
            .btn_n_raw_i (bus.btn_n_raw[g]),
            .level_o     (level_w[g]),
            .press_o     (press_w[g]),
            .release_o   (release_w[g]),
            .long_o      (long_w[g])
        );
    end

    // Every channel pressing in the same cycle is counted; the sum wraps modulo 64.
    always_comb begin
        press_inc_c = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            press_inc_c = press_inc_c + PRESS_CNT_W'(press_w[i]);
        end
    end

    assign press_count_d = press_count_q + press_inc_c;

    always_ff @(posedge clk50) begin
        if (rst) begin
            press_count_q <= '0;
        end else begin
            press_count_q <= press_count_d;
        end
    end

    assign bus.btn_level     = level_w;
    assign bus.press_pulse   = press_w;
    assign bus.release_pulse = release_w;
    assign bus.long_pulse    = long_w;
    assign bus.press_count   = press_count_q;

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side companion to the LED/blink output logic on the clk50 board.
- Conditions NUM_BTN asynchronous, bouncy, active-low push-buttons.
- Produces clean levels, single-cycle press/release/long-press strobes, and a 6-bit wrap-around press counter sized to drive the 6 board LEDs directly.

Parameters:
- NUM_BTN, 4, number of button channels.
- DEBOUNCE_CYCLES, 1000000, clocks a synchronized input must differ stably from btn_level before the level flips (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50000000, clocks of continuous debounced press before long_pulse fires (1 s); must exceed DEBOUNCE_CYCLES.
- CNT_W, 26, width of per-channel timers; must hold LONG_CYCLES.

Ports:
- clk50  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- btn_n_raw  in  NUM_BTN  raw pins, active-low, asynchronous to clk50.
- btn_level  out  NUM_BTN  debounced level, 1 = pressed.
- press_pulse  out  NUM_BTN  1-cycle strobe on debounced press.
- release_pulse  out  NUM_BTN  1-cycle strobe on debounced release.
- long_pulse  out  NUM_BTN  1-cycle strobe when press reaches LONG_CYCLES.
- press_count  out  6  total debounced presses, modulo 64.

Behaviour:
- Clock/reset: one clock, clk50; reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: btn_level=0, all pulses=0, press_count=0, timers=0, FSM=IDLE, synchronizer flops=1 (released).
- Synchronizer:
  - 2-flop synchronizer per bit, then inverted.
  - sync_n = synchronized pressed value.
- Per-channel FSM: IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE.
  - IDLE: sync_n=1 -> CONFIRM_PRESS, timer=1.
  - CONFIRM_PRESS:
    - sync_n=0 -> IDLE, timer=0 (glitch discarded).
    - Otherwise timer increments.
    - At timer==DEBOUNCE_CYCLES-1 -> HELD; btn_level<=1; press_pulse<=1 for one cycle; timer restarts at 0 as hold timer.
  - HELD:
    - Hold timer increments, saturating at LONG_CYCLES.
    - long_pulse fires exactly once, the cycle the timer reaches LONG_CYCLES.
    - sync_n=0 -> CONFIRM_RELEASE, debounce timer=1; the hold count is retained separately.
  - CONFIRM_RELEASE:
    - sync_n=1 -> HELD; the hold count resumes, so a release bounce does not re-arm long_pulse.
    - At DEBOUNCE_CYCLES-1 -> IDLE; btn_level<=0; release_pulse<=1; hold count cleared.
- Latency: a clean raw edge, held stable, changes btn_level exactly DEBOUNCE_CYCLES+2 clocks later; strobes assert in the same cycle as the level change.
- press_count:
  - Adds popcount(press_pulse) each cycle, modulo 64 (63+1 -> 0; 62+3 -> 1).
  - Simultaneous presses on several channels in one cycle are all counted.
- Simultaneous events: channels are fully independent; press and release of different channels in one cycle are both reported.
- Reset mid-press: all channels return to IDLE with no strobes. A button still held after reset is re-debounced and reported as a new press.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_LONG_PRESS_EN.
- Defined: long-press timing as described; CNT_W covers LONG_CYCLES.
- Undefined:
  - long_pulse tied to 0.
  - Hold timer and its comparator removed.
  - Timers sized only to DEBOUNCE_CYCLES.
  - All other behaviour identical.

Decomposition:
- Shared package button_pkg:
  - FSM state enum (IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE).
  - PRESS_CNT_W=6.
  - Default DEBOUNCE_CYCLES and LONG_CYCLES constants for 50 MHz.
- Sub-module debounce_chan:
  - Contains synchronizer, FSM and timers for one button.
  - Outputs level and the three strobes.
  - button_debouncer instantiates NUM_BTN copies via generate and owns the popcount adder and press_count.

Test Plan:
- Reset, then button 0 driven low for 20 cycles (DEBOUNCE_CYCLES=4) -> btn_level[0] rises at cycle 6 after the edge; one press_pulse[0]; press_count=1.
- Button 1 pulsed low for 3 cycles, then high -> no level change, no strobes, press_count unchanged.
- Button 2 bouncing low/high/low every cycle for 10 cycles, then low stable -> exactly one press_pulse, 6 cycles after the final stable edge.
- LONG_CYCLES=10, button 0 held 30 cycles with a 2-cycle release glitch midway -> exactly one long_pulse, no release_pulse until the real release.
- All 4 buttons pressed simultaneously 16 times -> press_count 0 -> 4 -> ... -> 60 -> 0 (wrap).
- Button held while rst pulses for 1 cycle -> all outputs 0 the cycle after rst; a new press_pulse follows DEBOUNCE_CYCLES+2 cycles later.
